// File: rtl/cal_pkg.sv
// Calendar date generator: shared mode codes and BCD date helpers.
// Years are passed as 16-bit BCD; 2-digit callers zero the upper pair.
package cal_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_HOLD = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v[3:0] != 4'd9)
      r = {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = 8'h00;
    return r;
  endfunction

  // Two BCD digits divisible by 4, decided on nibbles only.
  function automatic logic pair_div4(
    input logic [7:0] p
  );
    logic u048, u26;
    u048 = (p[3:0] == 4'd0) || (p[3:0] == 4'd4)
        || (p[3:0] == 4'd8);
    u26  = (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
    return p[4] ? u26 : u048;
  endfunction

  function automatic logic is_leap_bcd(
    input logic [15:0] yy,
    input logic        four
  );
    if (four && yy[7:0] == 8'h00)
      return pair_div4(yy[15:8]);
    return pair_div4(yy[7:0]);
  endfunction

  function automatic logic [7:0] days_in_month(
    input logic [7:0]  mm,
    input logic [15:0] yy,
    input logic        four,
    input logic        leap_en
  );
    logic [7:0] d;
    case (mm)
      8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
      8'h02:
        d = (leap_en && is_leap_bcd(yy, four))
          ? 8'h29 : 8'h28;
      default: d = 8'h31;
    endcase
    return d;
  endfunction

  function automatic logic date_valid(
    input logic [7:0]  dd,
    input logic [7:0]  mm,
    input logic [15:0] yy,
    input logic [2:0]  dow,
    input logic        four,
    input logic        leap_en
  );
    logic        ok;
    logic [31:0] all;
    all = {dd, mm, yy};
    ok  = 1'b1;
    for (int k = 0; k < 8; k++)
      if (all[4*k +: 4] > 4'd9) ok = 1'b0;
    if (mm < 8'h01 || mm > 8'h12) ok = 1'b0;
    if (dd < 8'h01) ok = 1'b0;
    if (dd > days_in_month(mm, yy, four, leap_en))
      ok = 1'b0;
    if (dow > 3'd6) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/calendar_next_day.sv
// Combinational next-day for a BCD {DD,MM,YY..} date and day of week.
// Input is assumed valid; only reset and checked loads create dates.
module calendar_next_day
  import cal_pkg::*;
#(
  parameter int YEAR_DIGITS = 2,
  parameter bit LEAP_EN     = 1'b1,
  localparam int YW = 4 * YEAR_DIGITS,
  localparam int DW = 16 + YW
) (
  input  logic [DW-1:0] date,
  input  logic [2:0]    dow,
  output logic [DW-1:0] next_date,
  output logic [2:0]    next_dow
);

  localparam bit FOUR = (YEAR_DIGITS == 4);

  logic [7:0]    dd, mm, dim;
  logic [7:0]    dd_n, mm_n;
  logic [YW-1:0] yw, yw_inc, yw_n;
  logic [15:0]   yy;

  assign dd  = date[DW-1 -: 8];
  assign mm  = date[DW-9 -: 8];
  assign yw  = date[YW-1:0];
  assign yy  = 16'(yw);
  assign dim = days_in_month(mm, yy, FOUR, LEAP_EN);

  generate
    if (YEAR_DIGITS == 4) begin : g_y4
      assign yw_inc = {
        (yw[7:0] == 8'h99) ? bcd_inc(yw[15:8])
                           : yw[15:8],
        bcd_inc(yw[7:0])
      };
    end else begin : g_y2
      assign yw_inc = bcd_inc(yw[7:0]);
    end
  endgenerate

  always_comb begin
    dd_n = bcd_inc(dd);
    mm_n = mm;
    yw_n = yw;
    if (dd == dim) begin
      dd_n = 8'h01;
      if (mm == 8'h12) begin
        mm_n = 8'h01;
        yw_n = yw_inc;
      end else begin
        mm_n = bcd_inc(mm);
      end
    end
  end

  assign next_date = {dd_n, mm_n, yw_n};
  assign next_dow  = (dow == 3'd6) ? 3'd0
                                   : dow + 3'd1;

endmodule

// File: rtl/calendar_date_gen.sv
// BCD calendar date counter advanced by the 23->00 hour wrap.
// Holds date/dow registers, rollover detect, pending flag, mode mux.
module calendar_date_gen
  import cal_pkg::*;
#(
  parameter int YEAR_DIGITS = 2,
  parameter bit LEAP_EN     = 1'b1,
  parameter logic [16+4*YEAR_DIGITS-1:0]
    RESET_DATE = 'h010100,
  parameter logic [2:0] RESET_DOW = 3'd6,
  localparam int YW = 4 * YEAR_DIGITS,
  localparam int DW = 16 + YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    hour_in,
  input  logic [DW-1:0] date_in,
  input  logic [2:0]    dow_in,
  input  logic [1:0]    date_mode,
  output logic [DW-1:0] date_out,
  output logic [2:0]    dow_out,
  output logic          day_tick,
  output logic          load_err
);

  logic [DW-1:0] date_q, date_nx;
  logic [2:0]    dow_q, dow_nx;
  logic [7:0]    hour_prev;
  logic [1:0]    mode_prev;
  logic          pending;
  logic          rollover;
  logic          load_ok;

  assign rollover = (hour_prev == 8'h23)
                 && (hour_in == 8'h00);

  assign load_ok = date_valid(
    date_in[DW-1 -: 8],
    date_in[DW-9 -: 8],
    16'(date_in[YW-1:0]),
    dow_in,
    YEAR_DIGITS == 4,
    LEAP_EN
  );

  calendar_next_day #(
    .YEAR_DIGITS (YEAR_DIGITS),
    .LEAP_EN     (LEAP_EN)
  ) u_next (
    .date      (date_q),
    .dow       (dow_q),
    .next_date (date_nx),
    .next_dow  (dow_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      date_q    <= RESET_DATE;
      dow_q     <= RESET_DOW;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
      hour_prev <= 8'h00;
      pending   <= 1'b0;
      mode_prev <= MODE_RUN;
    end else begin
      hour_prev <= hour_in;
      mode_prev <= date_mode;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
      case (date_mode)
        MODE_LOAD: begin
          if (load_ok) begin
            date_q  <= date_in;
            dow_q   <= dow_in;
            pending <= 1'b0;
          end else begin
            load_err <= 1'b1;
          end
        end
        MODE_STEP: begin
          if (mode_prev != MODE_STEP) begin
            date_q   <= date_nx;
            dow_q    <= dow_nx;
            day_tick <= 1'b1;
          end
          if (rollover) pending <= 1'b1;
        end
        MODE_HOLD: begin
          if (rollover) pending <= 1'b1;
        end
        default: begin
          // A pended day and a fresh wrap merge into one advance.
          if (rollover || pending) begin
            date_q   <= date_nx;
            dow_q    <= dow_nx;
            day_tick <= 1'b1;
          end
          pending <= 1'b0;
        end
      endcase
    end
  end

  assign date_out = date_q;
  assign dow_out  = dow_q;

endmodule

// File: tb/tb_calendar_date_gen.sv
// Bench for calendar_date_gen: 2-digit leap, 2-digit no-leap, 4-digit.
// Integer calendar model runs alongside directed and random stimulus.
module tb_calendar_date_gen;

  localparam logic [1:0] RUN  = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] STEP = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hour_in;
  logic [1:0]  date_mode;
  logic [2:0]  dow_in;
  logic [31:0] ld;
  logic [23:0] ld24;

  logic [23:0] date_a, date_b;
  logic [31:0] date_c;
  logic [2:0]  dow_a, dow_b, dow_c;
  logic        tick_a, tick_b, tick_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;

  int         m_dd[3], m_mm[3], m_yr[3], m_dw[3];
  bit         m_pend[3], m_tick[3], m_err[3];
  logic [7:0] hprev;
  logic [1:0] mprev;

  assign ld24 = {ld[31:16], ld[7:0]};

  always #5 clk = ~clk;

  calendar_date_gen u_a (
    .clk(clk), .rst(rst), .hour_in(hour_in),
    .date_in(ld24), .dow_in(dow_in),
    .date_mode(date_mode), .date_out(date_a),
    .dow_out(dow_a), .day_tick(tick_a),
    .load_err(err_a)
  );

  calendar_date_gen #(.LEAP_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .hour_in(hour_in),
    .date_in(ld24), .dow_in(dow_in),
    .date_mode(date_mode), .date_out(date_b),
    .dow_out(dow_b), .day_tick(tick_b),
    .load_err(err_b)
  );

  calendar_date_gen #(
    .YEAR_DIGITS(4),
    .RESET_DATE(32'h01012000)
  ) u_c (
    .clk(clk), .rst(rst), .hour_in(hour_in),
    .date_in(ld), .dow_in(dow_in),
    .date_mode(date_mode), .date_out(date_c),
    .dow_out(dow_c), .day_tick(tick_c),
    .load_err(err_c)
  );

  function automatic bit is_four(int i);
    return i == 2;
  endfunction

  function automatic bit leap(int y, bit four, bit en);
    if (!en) return 1'b0;
    if (four && y % 100 == 0) return (y / 100) % 4 == 0;
    return y % 4 == 0;
  endfunction

  function automatic int dim(int m, int y, int i);
    case (m)
      4, 6, 9, 11: return 30;
      2: return leap(y, is_four(i), i != 1) ? 29 : 28;
      default: return 31;
    endcase
  endfunction

  function automatic logic [7:0] b2(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [31:0] enc(int d, int m, int y);
    return {b2(d), b2(m), b2(y / 100), b2(y % 100)};
  endfunction

  function automatic logic [31:0] rand_date();
    int y, d;
    if ($urandom_range(0, 9) == 0) return $urandom;
    case ($urandom_range(0, 5))
      0: y = 1900;
      1: y = 2000;
      2: y = 2004;
      3: y = 1999;
      4: y = 9999;
      default: y = $urandom_range(0, 9999);
    endcase
    d = $urandom_range(0, 1) ? $urandom_range(27, 31)
                             : $urandom_range(1, 31);
    return enc(d, $urandom_range(1, 12), y);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dd[i] = 1; m_mm[i] = 1;
      m_yr[i] = is_four(i) ? 2000 : 0;
      m_dw[i] = 6;
      m_pend[i] = 0; m_tick[i] = 0; m_err[i] = 0;
    end
    hprev = 8'h00;
    mprev = RUN;
  endtask

  task automatic advance(int i);
    m_tick[i] = 1;
    m_dw[i] = (m_dw[i] + 1) % 7;
    m_dd[i]++;
    if (m_dd[i] > dim(m_mm[i], m_yr[i], i)) begin
      m_dd[i] = 1;
      m_mm[i]++;
      if (m_mm[i] > 12) begin
        m_mm[i] = 1;
        m_yr[i] = (m_yr[i] + 1) % (is_four(i) ? 10000 : 100);
      end
    end
  endtask

  task automatic try_load(int i);
    logic [31:0] v;
    bit ok;
    int dd, mm, yr;
    v = is_four(i) ? ld : {ld[31:16], 8'h00, ld[7:0]};
    ok = 1;
    for (int k = 0; k < 8; k++)
      if (int'(v[4*k +: 4]) > 9) ok = 0;
    dd = 10 * int'(v[31:28]) + int'(v[27:24]);
    mm = 10 * int'(v[23:20]) + int'(v[19:16]);
    yr = 1000 * int'(v[15:12]) + 100 * int'(v[11:8])
       + 10 * int'(v[7:4]) + int'(v[3:0]);
    if (mm < 1 || mm > 12) ok = 0;
    else if (dd < 1 || dd > dim(mm, yr, i)) ok = 0;
    if (int'(dow_in) > 6) ok = 0;
    if (ok) begin
      m_dd[i] = dd; m_mm[i] = mm; m_yr[i] = yr;
      m_dw[i] = int'(dow_in);
      m_pend[i] = 0;
    end else begin
      m_err[i] = 1;
    end
  endtask

  task automatic model_edge();
    bit roll;
    roll = (hprev == 8'h23) && (hour_in == 8'h00);
    for (int i = 0; i < 3; i++) begin
      m_tick[i] = 0;
      m_err[i] = 0;
      case (date_mode)
        LOAD: try_load(i);
        STEP: begin
          if (mprev != STEP) advance(i);
          if (roll) m_pend[i] = 1;
        end
        HOLD: if (roll) m_pend[i] = 1;
        default: begin
          if (roll || m_pend[i]) advance(i);
          m_pend[i] = 0;
        end
      endcase
    end
    hprev = hour_in;
    mprev = date_mode;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_inst(string tag, int i,
                          logic [31:0] d, logic [2:0] w,
                          logic t, logic er);
    logic [31:0] e;
    e = enc(m_dd[i], m_mm[i], m_yr[i]);
    if (!is_four(i)) e = {8'h00, e[31:16], e[7:0]};
    chk({tag, ".date"}, d, e);
    chk({tag, ".dow"}, 32'(w), 32'(m_dw[i]));
    chk({tag, ".tick"}, 32'(t), 32'(m_tick[i]));
    chk({tag, ".err"}, 32'(er), 32'(m_err[i]));
  endtask

  task automatic check_all(string tag);
    chk_inst({tag, "/a"}, 0, {8'h00, date_a},
             dow_a, tick_a, err_a);
    chk_inst({tag, "/b"}, 1, {8'h00, date_b},
             dow_b, tick_b, err_b);
    chk_inst({tag, "/c"}, 2, date_c,
             dow_c, tick_c, err_c);
  endtask

  task automatic cyc(string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic roll(string tag);
    hour_in = 8'h23;
    cyc({tag, "_h23"});
    hour_in = 8'h00;
    cyc({tag, "_h00"});
  endtask

  task automatic load(string tag, logic [31:0] v,
                      logic [2:0] w);
    date_mode = LOAD;
    ld = v;
    dow_in = w;
    cyc(tag);
  endtask

  task automatic do_reset(string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hour_in = 8'h00;
    date_mode = RUN;
    dow_in = 3'd0;
    ld = 32'h0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    hour_in = 8'h05;
    cyc("first_run");

    load("t1_load", 32'h28022003, 3'd2);
    date_mode = RUN;
    roll("t1_roll");
    cyc("t1_tick_gone");

    load("t2_load", 32'h28022004, 3'd1);
    date_mode = RUN;
    roll("t2_roll1");
    roll("t2_roll2");

    load("t3_load", 32'h31122004, 3'd4);
    date_mode = RUN;
    roll("t3_roll");
    load("t3_bad", 32'h31042005, 3'd0);
    load("t3_nib", 32'h3A012005, 3'd0);
    load("t3_dow", 32'h01012005, 3'd7);

    date_mode = HOLD;
    roll("t4_hold1");
    roll("t4_hold2");
    cyc("t4_hold3");
    date_mode = RUN;
    hour_in = 8'h01;
    cyc("t4_run1");
    cyc("t4_run2");

    load("t5_load", 32'h30061999, 3'd3);
    date_mode = STEP;
    for (int k = 0; k < 5; k++) cyc("t5_step");
    load("t5_ylod", 32'h31121999, 3'd3);
    date_mode = STEP;
    cyc("t5_ywrap");
    cyc("t5_yhold");

    load("t6_1900", 32'h28021900, 3'd0);
    date_mode = STEP;
    cyc("t6_1900s");
    load("t6_2000", 32'h28022000, 3'd0);
    date_mode = STEP;
    cyc("t6_2000s");
    do_reset("t6_rst_step");
    cyc("t6_post_rst");

    date_mode = RUN;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0)
        date_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        hour_in = (hour_in == 8'h23) ? 8'h00 : 8'h23;
      else
        hour_in = b2($urandom_range(0, 23));
      ld = rand_date();
      dow_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
